// File: rtl/regfile_dump_if.sv
// Valid/ready stream carrying one register value and its address per word.
// The master drives the word and the slave answers with ready.
interface regfile_dump_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] addr;
   logic              last;

   modport master (output valid, output data, output addr, output last, input ready);
   modport slave  (input valid, input data, input addr, input last, output ready);
endinterface

// File: rtl/regfile_dump.sv
// Streams a wrap-around register-file address range out as tagged words.
// It also keeps a running 16-bit checksum of every word it emits.
module regfile_dump #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] first_addr_i,
   input  logic [ADDR_W-1:0] last_addr_i,
   output logic [ADDR_W-1:0] rf_raddr_o,
   input  logic [DATA_W-1:0] rf_rdata_i,
   regfile_dump_if.master    out_if,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] checksum_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              last_q, last_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] sum_q, sum_d;

   always_comb begin
      // NOTE: every _d starts as its _q so no branch can leave one unassigned and infer a latch.
      state_d = state_q;
      ptr_d   = ptr_q;
      end_d   = end_q;
      data_d  = data_q;
      addr_d  = addr_q;
      last_d  = last_q;
      valid_d = valid_q;
      sum_d   = sum_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               ptr_d   = first_addr_i;
               end_d   = last_addr_i;
               sum_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // The word is a snapshot of the register taken at this edge.
            data_d  = rf_rdata_i;
            addr_d  = ptr_q;
            last_d  = (ptr_q == end_q);
            sum_d   = sum_q + rf_rdata_i;
            valid_d = 1'b1;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (out_if.ready) begin
               valid_d = 1'b0;
               if (last_q) begin
                  state_d = S_DONE;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  state_d = S_LOAD;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         end_q   <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         sum_q   <= '0;
      end else begin
         // NOTE: non-blocking so every register updates from pre-edge values.
         state_q <= state_d;
         ptr_q   <= ptr_d;
         end_q   <= end_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         sum_q   <= sum_d;
      end
   end

   assign rf_raddr_o   = ptr_q;
   assign out_if.valid = valid_q;
   assign out_if.data  = data_q;
   assign out_if.addr  = addr_q;
   assign out_if.last  = last_q;
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_DONE);
   assign checksum_o   = sum_q;

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Read-side streaming engine for the 16 x 16-bit register file. On a start request it walks a programmable, wrap-around address range through one register-file read port and emits each register value as a valid/ready stream word tagged with its address. It also accumulates a 16-bit checksum of all emitted words. The block is used for debug readout, context save and test-bench comparison of architectural state, and sits beside the core on the register file's read side.

## Interface
- DATA_W, 16, register width and stream data width
- ADDR_W, 4, register address width; the range walks modulo 2^ADDR_W

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a dump; sampled only in IDLE
- first_addr  in  ADDR_W  first register to emit; sampled when start is accepted
- last_addr  in  ADDR_W  last register to emit; sampled when start is accepted
- rf_raddr  out  ADDR_W  read address to the register file (combinational read)
- rf_rdata  in  DATA_W  read data returned by the register file for rf_raddr
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  DATA_W  register value
- out_addr  out  ADDR_W  register address of out_data
- out_last  out  1  marks the final word of the dump
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the final handshake
- checksum  out  DATA_W  running sum of emitted words, modulo 2^DATA_W

## Operation
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - busy=0.
  - start=1 -> ptr<=first_addr, end<=last_addr, checksum<=0, go to LOAD.
- LOAD:
  - rf_raddr=ptr.
  - At the clock edge: out_data<=rf_rdata, out_addr<=ptr, out_last<=(ptr==end), checksum<=checksum+rf_rdata, out_valid<=1, go to SEND.
- SEND:
  - out_valid=1. All out_* signals are held stable until out_valid && out_ready.
  - On the handshake: out_valid<=0.
    - If out_last=1, go to DONE.
    - Otherwise ptr<=ptr+1 (wraps 15->0) and go to LOAD.
- DONE: done=1 for one cycle, then go to IDLE.
- checksum holds its value from DONE until the next accepted start.
- rf_raddr always equals ptr, including in IDLE and while stalled.
- Word count is ((last_addr-first_addr) mod 16)+1.
  - first_addr==last_addr emits one word.
  - last_addr<first_addr wraps through address 15 to 0.
- Address 0 is emitted like any other register. Its value is whatever rf_rdata returns, which is 0 from the register file.
- Register writes that occur during a dump are visible only if they land before that word's LOAD edge. Each word is a snapshot taken at its LOAD edge.
- start outside IDLE is ignored. There is no abort input; rst is the only way to cancel a dump.

## Timing
- Reset values: state=IDLE, ptr=0, rf_raddr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0, checksum=0.
- rst asserted mid-dump clears every output immediately (asynchronously), including dropping out_valid. The partial dump is discarded.
- If start is accepted at edge N:
  - busy=1 from N, LOAD during cycle N..N+1.
  - out_valid=1 from edge N+1.
- With out_ready held high, each word takes 2 cycles (LOAD + SEND). A dump of k words ends its final handshake at edge N+2k.
- done is high for exactly the cycle after the final handshake edge. busy falls together with done.
- A new start is accepted no earlier than the cycle after the done cycle.

## Test plan
- Preload r_i=16'h1000+i. Dump first=0, last=15 with out_ready=1 -> 16 words:
  - addr 0..15, data 0, 1001..100F.
  - out_last only on addr 15; done 32 cycles after start.
  - checksum=16'hF078.
- Same preload, first=14, last=1 -> words (14,100E), (15,100F), (0,0000), (1,1001), out_last on addr 1, checksum=16'h301E.
- Dump first=3, last=4 with out_ready low for 5 cycles while out_valid=1 -> out_data=1003 and out_addr=3 stay stable. Both words are delivered once ready rises; no word is duplicated or dropped.
- Dump first=last=5 with a second start pulse while busy -> exactly one word (5,1005) with out_last=1 and one done pulse. The second start has no effect.
- Assert rst while word (7,1007) is valid -> out_valid, busy and checksum read 0 in the same cycle. A following dump with first=7, last=7 then runs normally.
- Preload all registers to 16'hFFFF and dump first=1, last=15 -> checksum wraps to 16'hFFF1.
